// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA pixel stream bundle passed from the timing source through drawing stages
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_out (
    output hcount,
    output vcount,
    output hsync,
    output vsync,
    output hblnk,
    output vblnk,
    output rgb
  );

  modport vga_in (
    input hcount,
    input vcount,
    input hsync,
    input vsync,
    input hblnk,
    input vblnk,
    input rgb
  );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 800x600@60 VGA counter/sync/blank generator with frame-start strobe
// Flags are decoded from the next counter values so counts and flags leave the same register stage.
module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic     clk,
  input  logic     rst,
  vga_if.vga_out   vga_out,
  output logic     frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLANK    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_BLANK    = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [10:0] hcount_nxt;
  logic [10:0] vcount_nxt;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        h_wrap;
  logic        v_wrap;

  // Wrap by explicit compare so non-power-of-two totals never rely on overflow.
  always_comb begin
    h_wrap     = (hcount == H_LAST);
    v_wrap     = (vcount == V_LAST);
    hcount_nxt = h_wrap ? 11'd0 : hcount + 11'd1;
    vcount_nxt = vcount;
    if (h_wrap) begin
      vcount_nxt = v_wrap ? 11'd0 : vcount + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= hcount_nxt;
      vcount      <= vcount_nxt;
      hblnk       <= (hcount_nxt >= H_BLANK);
      hsync       <= (hcount_nxt >= H_SYNC_ON) && (hcount_nxt < H_SYNC_OFF);
      vblnk       <= (vcount_nxt >= V_BLANK);
      vsync       <= (vcount_nxt >= V_SYNC_ON) && (vcount_nxt < V_SYNC_OFF);
      // Only a genuine (last,last) wrap strobes; the (0,0) held out of reset does not.
      frame_start <= h_wrap && v_wrap;
    end
  end

  assign vga_out.hcount = hcount;
  assign vga_out.vcount = vcount;
  assign vga_out.hsync  = hsync;
  assign vga_out.vsync  = vsync;
  assign vga_out.hblnk  = hblnk;
  assign vga_out.vblnk  = vblnk;
  assign vga_out.rgb    = 12'h000;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - randomized self-checking bench for vga_timing (default and reduced geometry)
module tb_vga_timing;

  logic clk;
  logic rst;
  logic fs_big;
  logic fs_sml;
  int   cyc;
  int   checks;
  int   errors;

  vga_if vb ();
  vga_if vs ();

  vga_timing dut_big (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (vb),
    .frame_start (fs_big)
  );

  vga_timing #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4),  .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) dut_sml (
    .clk         (clk),
    .rst         (rst),
    .vga_out     (vs),
    .frame_start (fs_sml)
  );

  logic [38:0] big_vec;
  logic [38:0] sml_vec;
  assign big_vec = {vb.hcount, vb.vcount, vb.hsync, vb.vsync, vb.hblnk, vb.vblnk, fs_big, vb.rgb};
  assign sml_vec = {vs.hcount, vs.vcount, vs.hsync, vs.vsync, vs.hblnk, vs.vblnk, fs_sml, vs.rgb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks elapsed since reset release; the reference is a pure function of this.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [38:0] model(input int n, input int ha, input int hf, input int hs,
                                        input int hb, input int va, input int vf, input int vsw,
                                        input int vbp);
    int ht;
    int vt;
    int h;
    int v;
    logic e_hs;
    logic e_vs;
    logic e_hb;
    logic e_vb;
    logic e_fs;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vsw + vbp;
    h    = n % ht;
    v    = (n / ht) % vt;
    e_hb = (h >= ha);
    e_hs = (h >= ha + hf) && (h < ha + hf + hs);
    e_vb = (v >= va);
    e_vs = (v >= va + vf) && (v < va + vf + vsw);
    e_fs = (n > 0) && (n % (ht * vt) == 0);
    return {11'(h), 11'(v), e_hs, e_vs, e_hb, e_vb, e_fs, 12'h000};
  endfunction

  function automatic logic [38:0] exp_big(input int n);
    return model(n, 800, 40, 128, 88, 600, 1, 4, 23);
  endfunction

  function automatic logic [38:0] exp_sml(input int n);
    return model(n, 16, 2, 3, 3, 4, 1, 1, 1);
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int run;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (big_vec !== 39'd0 || sml_vec !== 39'd0) begin
      errors++;
      $display("FAIL reset_por big=%h sml=%h expected=0", big_vec, sml_vec);
    end
    rst = 1'b0;
    run = $urandom_range(300, 1500);
    repeat (run) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (big_vec !== 39'd0 || sml_vec !== 39'd0) begin
      errors++;
      $display("FAIL reset_async big=%h sml=%h expected=0", big_vec, sml_vec);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (big_vec !== 39'd0 || sml_vec !== 39'd0) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d big=%h sml=%h expected=0", i, big_vec, sml_vec);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (vb.hcount !== 11'(k) || vb.vcount !== 11'd0 || fs_big !== 1'b0) begin
        errors++;
        $display("FAIL reset_release h=%0d v=%0d fs=%b expected h=%0d v=0 fs=0",
                 vb.hcount, vb.vcount, fs_big, k);
      end
    end
  endtask

  task automatic test_horizontal();
    int lines;
    pulse_reset();
    lines = $urandom_range(3, 5);
    for (int i = 0; i < lines * 1056; i++) begin
      @(negedge clk);
      checks++;
      if (big_vec !== exp_big(cyc)) begin
        errors++;
        $display("FAIL horizontal cyc=%0d actual=%h expected=%h", cyc, big_vec, exp_big(cyc));
      end
    end
  endtask

  task automatic test_vertical();
    pulse_reset();
    for (int i = 0; i < 2 * 168 + $urandom_range(5, 40); i++) begin
      @(negedge clk);
      checks++;
      if (sml_vec !== exp_sml(cyc)) begin
        errors++;
        $display("FAIL vertical cyc=%0d actual=%h expected=%h", cyc, sml_vec, exp_sml(cyc));
      end
    end
  endtask

  task automatic test_frame_period();
    int  n;
    bit  found;
    pulse_reset();
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (fs_sml) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_first no strobe within 400 cycles, expected one at 168");
    end
    for (int p = 0; p < 2; p++) begin
      n = 0;
      found = 1'b0;
      while (!found && n < 400) begin
        @(negedge clk);
        n++;
        if (n == 1) begin
          checks++;
          if (fs_sml !== 1'b0) begin
            errors++;
            $display("FAIL frame_width strobe still high one cycle later, expected 0");
          end
        end
        if (fs_sml) found = 1'b1;
      end
      checks++;
      if (n !== 168) begin
        errors++;
        $display("FAIL frame_period actual=%0d expected=168", n);
      end
      checks++;
      if (vs.hcount !== 11'd0 || vs.vcount !== 11'd0) begin
        errors++;
        $display("FAIL frame_pos h=%0d v=%0d expected h=0 v=0", vs.hcount, vs.vcount);
      end
    end
  endtask

  task automatic test_invariants();
    bit bad;
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bad = (vb.hsync && !vb.hblnk) || (vb.vsync && !vb.vblnk) ||
            (vs.hsync && !vs.hblnk) || (vs.vsync && !vs.vblnk) ||
            (vb.hcount > 11'd1055) || (vb.vcount > 11'd627) ||
            (vs.hcount > 11'd23) || (vs.vcount > 11'd6) ||
            (vb.rgb !== 12'h000) || (vs.rgb !== 12'h000);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL invariant cyc=%0d big=%h sml=%h", cyc, big_vec, sml_vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    int run;
    for (int r = 0; r < 4; r++) begin
      run = $urandom_range(1, 600);
      for (int i = 0; i < run; i++) begin
        @(negedge clk);
        checks++;
        if (big_vec !== exp_big(cyc) || sml_vec !== exp_sml(cyc)) begin
          errors++;
          $display("FAIL b2b_run cyc=%0d big=%h/%h sml=%h/%h", cyc, big_vec, exp_big(cyc),
                   sml_vec, exp_sml(cyc));
        end
      end
      #($urandom_range(1, 3)) rst = 1'b1;
      #1;
      checks++;
      if (big_vec !== 39'd0 || sml_vec !== 39'd0) begin
        errors++;
        $display("FAIL b2b_reset big=%h sml=%h expected=0", big_vec, sml_vec);
      end
      repeat ($urandom_range(1, 5)) @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_horizontal();
    test_vertical();
    test_frame_period();
    test_invariants();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Source end of the `vga_if` pixel stream. Generates horizontal and vertical counters, sync pulses and blanking flags for 800x600 @ 60 Hz (40 MHz pixel clock). It feeds the first drawing stage (background, then start box, etc.), which only reads `vga_if` and passes it on. It also provides a one-cycle frame-start strobe for game logic that must update between frames.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)

Ports:
- clk  input  1  pixel clock, 40 MHz, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- vga_out  modport vga_if.vga_out  drives hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
- frame_start  output  1  single-cycle strobe at the first pixel of each new frame

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- hcount counts 0..H_TOTAL-1 and increments every clock.
  - At H_TOTAL-1 it wraps to 0, and vcount advances.
- vcount counts 0..V_TOTAL-1 and changes only on an hcount wrap.
  - At V_TOTAL-1 with an hcount wrap, vcount wraps to 0.
- Flags are decoded from the counter values shown in the same cycle (no skew between counts and flags):
  - hblnk = 1 iff hcount >= H_ACTIVE (800..1055)
  - hsync = 1 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (840..967)
  - vblnk = 1 iff vcount >= V_ACTIVE (600..627)
  - vsync = 1 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (601..604)
- Sync polarity is positive (1 = sync active).
- rgb is tied to 12'h000. Drawing stages overwrite it.
- frame_start = 1 only in the cycle where hcount=0 and vcount=0 following a wrap from (1055,627).
- All outputs except rgb are registers. Each flag is computed from the next counter value, so it is registered together with its count.
- Counter arithmetic is 11-bit unsigned. Wrap is by explicit compare to TOTAL-1, never by overflow.

## Timing
- Reset (asynchronous, immediate): hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0. These are consistent with pixel (0,0) being visible.
- First rising edge after rst deasserts: hcount=1, vcount=0.
- frame_start is not asserted for the (0,0) held during or right after reset. The first strobe comes after a full frame.
- Line period: 1056 clocks. Frame period: 1056*628 = 663168 clocks.
- Wrap cycle sequence:
  - (1055, v) -> (0, v+1) for v < 627
  - (1055, 627) -> (0, 0), with frame_start=1 in the (0,0) cycle only
- During line 600 the vblnk rise coincides with hcount=0, so the change is line-aligned.
- Reset asserted mid-frame: counters and flags return to reset values asynchronously, and counting restarts from (0,0) on release. No partial strobe.
- Latency from counter value to flags: 0 cycles, by construction.

## Test plan
- Reset: hold rst for 5 cycles mid-frame -> all outputs 0 immediately. After release, hcount goes 1,2,3 on successive edges with vcount=0, and frame_start stays 0.
- Horizontal edges:
  - at hcount 799/800: hblnk goes 0 -> 1
  - at hcount 839/840: hsync goes 0 -> 1
  - at hcount 967/968: hsync goes 1 -> 0
  - at hcount 1055 -> 0: hblnk goes 1 -> 0 and vcount goes from v to v+1
- Vertical edges:
  - at vcount 599/600: vblnk goes 0 -> 1
  - at vcount 601: vsync goes 1, and stays 1 through vcount 604
  - at vcount 605: vsync goes 0
  - vblnk falls at (0,0)
- Frame period: count cycles between consecutive frame_start pulses -> exactly 663168. Each pulse is 1 cycle wide and has hcount=0, vcount=0.
- Invariants over two full frames:
  - hsync implies hblnk, and vsync implies vblnk
  - hcount never exceeds 1055 and vcount never exceeds 627
  - rgb is always 12'h000
- Parameter override (H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1) -> line period 24, frame period 168, hsync on at hcount 18..20, vsync on at vcount 5.
